dvi_tmds_encoder: RTL

- Downstream stage of the colour-bar pattern generator.
- Consumes the generator's registered RGB/DE and syncgen's HS/VS on the pixel clock.
- Produces three 10-bit TMDS symbols per pixel (DVI 1.0 8b/10b with DC balancing) for the serializer / OSERDES stage.
- Channel 0 = blue + {VS,HS}; channel 1 = green; channel 2 = red.

---
 rtl/dvi_tmds_encoder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dvi_tmds_encoder.sv
// DVI 1.0 TMDS encoder: three 8b/10b DC-balanced lanes, 2-cycle pipeline on PCK.
// Lane 0 carries blue plus {VS,HS} during blanking; lanes 1/2 carry green/red.

module dvi_tmds_lane (
  input  logic       pck_i,
  input  logic       rst_i,
  input  logic [7:0] d_i,
  input  logic       de_s1_i,
  input  logic [1:0] ctl_s1_i,
  output logic [9:0] sym_o
);

  logic [8:0]        q_m_d, q_m_q;
  logic [9:0]        sym_d, sym_q;
  logic signed [4:0] cnt_d, cnt_q;

  logic [3:0]        n1d;
  logic              use_xnor;
  logic [3:0]        n1;
  logic signed [5:0] bal, cnt_x, delta, cnt_sum;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + {3'b000, v[i]};
    return s;
  endfunction

  // Stage 1: transition-minimising chain
  always_comb begin
    n1d      = popcnt8(d_i);
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !d_i[0]);
    q_m_d    = '0;
    q_m_d[0] = d_i[0];
    for (int i = 1; i < 8; i++)
      q_m_d[i] = use_xnor ? ~(q_m_d[i-1] ^ d_i[i]) : (q_m_d[i-1] ^ d_i[i]);
    q_m_d[8] = ~use_xnor;
  end

  // Stage 2: DC balancing; bal = N1 - N0 = 2*N1 - 8
  always_comb begin
    n1    = popcnt8(q_m_q[7:0]);
    bal   = $signed({1'b0, n1, 1'b0}) - 6'sd8;
    cnt_x = {cnt_q[4], cnt_q};
    sym_d = 10'h354;
    delta = '0;
    if (!de_s1_i) begin
      case (ctl_s1_i)
        2'b00:   sym_d = 10'h354;
        2'b01:   sym_d = 10'h0AB;
        2'b10:   sym_d = 10'h154;
        default: sym_d = 10'h2AB;
      endcase
    end else if ((cnt_q == 5'sd0) || (bal == 6'sd0)) begin
      sym_d = {~q_m_q[8], q_m_q[8], q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0]};
      delta = q_m_q[8] ? bal : -bal;
    end else if ((!cnt_q[4] && (bal > 6'sd0)) || (cnt_q[4] && (bal < 6'sd0))) begin
      sym_d = {1'b1, q_m_q[8], ~q_m_q[7:0]};
      delta = (q_m_q[8] ? 6'sd2 : 6'sd0) - bal;
    end else begin
      sym_d = {1'b0, q_m_q[8], q_m_q[7:0]};
      delta = bal - (q_m_q[8] ? 6'sd0 : 6'sd2);
    end
    cnt_sum = cnt_x + delta;
    cnt_d   = de_s1_i ? $signed(cnt_sum[4:0]) : 5'sd0;
  end

  always_ff @(posedge pck_i) begin
    if (rst_i) begin
      q_m_q <= '0;
      sym_q <= 10'h354;
      cnt_q <= '0;
    end else begin
      q_m_q <= q_m_d;
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

endmodule

module dvi_tmds_encoder #(
  parameter int SYNC_DELAY = 1
) (
  input  logic       PCK,
  input  logic       RST,
  input  logic [7:0] VGA_R,
  input  logic [7:0] VGA_G,
  input  logic [7:0] VGA_B,
  input  logic       VGA_HS,
  input  logic       VGA_VS,
  input  logic       VGA_DE,
  output logic [9:0] TMDS_CH0,
  output logic [9:0] TMDS_CH1,
  output logic [9:0] TMDS_CH2,
  output logic       TMDS_DE
);

  localparam int NUM_LANES = 3;
  localparam int VEC_W     = 8;
  localparam int STAGES    = 2;

  logic [NUM_LANES-1:0][VEC_W-1:0] pix;
  logic [NUM_LANES-1:0][9:0]       sym;
  logic [1:0]                      sync_dly;
  logic [STAGES:1]                 de_pipe_q;
  logic [1:0]                      ctl_s1_q;

  assign pix = {VGA_R, VGA_G, VGA_B};

  // Sync is realigned with the already-registered RGB/DE from the generator
  generate
    if (SYNC_DELAY == 0) begin : g_sync_thru
      assign sync_dly = {VGA_VS, VGA_HS};
    end else begin : g_sync_dly
      logic [SYNC_DELAY-1:0][1:0] sync_q;
      always_ff @(posedge PCK) begin
        if (RST) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= {VGA_VS, VGA_HS};
          for (int i = 1; i < SYNC_DELAY; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign sync_dly = sync_q[SYNC_DELAY-1];
    end
  endgenerate

  always_ff @(posedge PCK) begin
    if (RST) begin
      de_pipe_q <= '0;
      ctl_s1_q  <= '0;
    end else begin
      de_pipe_q <= {de_pipe_q[STAGES-1:1], VGA_DE};
      ctl_s1_q  <= sync_dly;
    end
  end

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      dvi_tmds_lane u_lane (
        .pck_i    (PCK),
        .rst_i    (RST),
        .d_i      (pix[l]),
        .de_s1_i  (de_pipe_q[1]),
        .ctl_s1_i ((l == 0) ? ctl_s1_q : 2'b00),
        .sym_o    (sym[l])
      );
    end
  endgenerate

  assign TMDS_CH0 = sym[0];
  assign TMDS_CH1 = sym[1];
  assign TMDS_CH2 = sym[2];
  assign TMDS_DE  = de_pipe_q[STAGES];

endmodule
